// File: rtl/median_pkg.sv
// -----------------------------------------------------------------------------
// median_pkg
// Shared definitions for the median filter core, its line buffer and CSR block.
//   LINE_LEN / NUM_LINES / WIDTH / IDX_W : default geometry (pixels per line,
//                                          lines per frame, bits per pixel,
//                                          line index width)
//   LINE_BITS                            : bits in one assembled line
//   lb_state_e                           : line buffer FSM states
// -----------------------------------------------------------------------------
package median_pkg;

    localparam int LINE_LEN  = 256;
    localparam int NUM_LINES = 256;
    localparam int WIDTH     = 8;
    localparam int IDX_W     = 9;
    localparam int LINE_BITS = LINE_LEN * WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } lb_state_e;

endpackage

// File: rtl/median_line_buffer_if.sv
// -----------------------------------------------------------------------------
// median_line_buffer_if
// Pixel stream in, 3-line window bus out, for median_line_buffer.
//   pix_data / pix_valid / pix_sof / pix_ready : raster pixel stream
//   win_out / win_valid / line_idx / frame_done: window bus to the core
//   state_dbg                                  : line buffer FSM state
// Modports: slave  = the line buffer (consumes pixels, drives windows)
//           master = the upstream source / bench
//
// Handshake: a pixel transfers on a rising clk edge where pix_valid and
// pix_ready are both 1. The source holds pix_data/pix_sof stable while
// pix_valid is high and not yet accepted; pix_ready does not depend
// combinationally on pix_valid. The window bus has no back-pressure:
// win_valid is a one-cycle pulse and win_out holds between pulses.
// -----------------------------------------------------------------------------
interface median_line_buffer_if #(
    parameter int LINE_LEN = median_pkg::LINE_LEN,
    parameter int WIDTH    = median_pkg::WIDTH,
    parameter int IDX_W    = median_pkg::IDX_W
);
    logic [WIDTH-1:0]            pix_data;
    logic                        pix_valid;
    logic                        pix_sof;
    logic                        pix_ready;
    logic [3*LINE_LEN*WIDTH-1:0] win_out;
    logic                        win_valid;
    logic [IDX_W-1:0]            line_idx;
    logic                        frame_done;
    median_pkg::lb_state_e       state_dbg;

    modport slave (
        input  pix_data, pix_valid, pix_sof,
        output pix_ready, win_out, win_valid, line_idx, frame_done, state_dbg
    );

    modport master (
        output pix_data, pix_valid, pix_sof,
        input  pix_ready, win_out, win_valid, line_idx, frame_done, state_dbg
    );
endinterface

// File: rtl/median_line_asm.sv
// -----------------------------------------------------------------------------
// median_line_asm
// Shift-register line assembler with column counter.
//   clk, rst  : clock, asynchronous active-high reset
//   push      : an accepted pixel is to be stored this cycle
//   restart   : the pushed pixel is column 0 (start of frame)
//   pix_data  : pixel value
//   line_done : combinational, this push completes a line
//   line_vec  : combinational, line contents including this push
//               (column 0 at the LSBs once a line is complete)
// -----------------------------------------------------------------------------
module median_line_asm #(
    parameter int LINE_LEN = median_pkg::LINE_LEN,
    parameter int WIDTH    = median_pkg::WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      restart,
    input  logic [WIDTH-1:0]          pix_data,
    output logic                      line_done,
    output logic [LINE_LEN*WIDTH-1:0] line_vec
);
    localparam int ROW_BITS = LINE_LEN * WIDTH;
    localparam int CNT_W    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(LINE_LEN - 1);

    logic [ROW_BITS-1:0] line_asm_q, line_asm_d;
    logic [CNT_W-1:0]    col_cnt_q, col_cnt_d;
    logic [CNT_W-1:0]    col_now;

    always_comb begin
        // A restart pixel is column 0 regardless of where the count was.
        col_now    = restart ? '0 : col_cnt_q;
        line_asm_d = line_asm_q;
        col_cnt_d  = col_cnt_q;
        line_done  = 1'b0;
        if (push) begin
            // New pixel enters at the MS end; after LINE_LEN pushes the first
            // pixel of the line has walked down to the LSBs.
            line_asm_d = {pix_data, line_asm_q[ROW_BITS-1:WIDTH]};
            line_done  = (col_now == LAST_COL);
            col_cnt_d  = line_done ? '0 : col_now + CNT_W'(1);
        end
        line_vec = line_asm_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_asm_q <= '0;
            col_cnt_q  <= '0;
        end else begin
            line_asm_q <= line_asm_d;
            col_cnt_q  <= col_cnt_d;
        end
    end
endmodule

// File: rtl/median_line_buffer.sv
// -----------------------------------------------------------------------------
// median_line_buffer
// Assembles a raster pixel stream into lines and emits 3-line windows
// {above, centre, below} for the median core, with border lines at the top
// and bottom of each frame.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : median_line_buffer_if.slave
//              pix_data/pix_valid/pix_sof/pix_ready in,
//              win_out/win_valid/line_idx/frame_done/state_dbg out
// Build option: define MEDIAN_LB_REPLICATE_EN to use the nearest edge line as
// the border line instead of all-zero pixels.
// -----------------------------------------------------------------------------
module median_line_buffer #(
    parameter int LINE_LEN  = median_pkg::LINE_LEN,
    parameter int NUM_LINES = median_pkg::NUM_LINES,
    parameter int WIDTH     = median_pkg::WIDTH,
    parameter int IDX_W     = median_pkg::IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    median_line_buffer_if.slave  bus
);
    import median_pkg::*;

    localparam int ROW_BITS = LINE_LEN * WIDTH;
    localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(NUM_LINES - 1);

    lb_state_e             state_q, state_d;
    logic [ROW_BITS-1:0]   line_top_q, line_top_d;
    logic [ROW_BITS-1:0]   line_mid_q, line_mid_d;
    logic [IDX_W-1:0]      line_cnt_q, line_cnt_d;
    logic [3*ROW_BITS-1:0] win_out_q, win_out_d;
    logic                  win_valid_q, win_valid_d;
    logic [IDX_W-1:0]      line_idx_q, line_idx_d;
    logic                  frame_done_q, frame_done_d;
    logic                  pix_ready_q, pix_ready_d;

    logic                  accept;
    logic                  push;
    logic                  restart;
    logic                  line_done;
    logic [ROW_BITS-1:0]   line_vec;
    logic [ROW_BITS-1:0]   border_top;
    logic [ROW_BITS-1:0]   border_bot;

    assign accept = bus.pix_valid && pix_ready_q;

    // Which accepted pixels reach the assembler. In IDLE only a start-of-frame
    // pixel is kept; anything else is discarded.
    always_comb begin
        push    = 1'b0;
        restart = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && bus.pix_sof) begin
                    push    = 1'b1;
                    restart = 1'b1;
                end
            end
            FIRST, STREAM: begin
                if (accept) begin
                    push    = 1'b1;
                    restart = bus.pix_sof;
                end
            end
            default: ;
        endcase
    end

    median_line_asm #(
        .LINE_LEN (LINE_LEN),
        .WIDTH    (WIDTH)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .restart   (restart),
        .pix_data  (bus.pix_data),
        .line_done (line_done),
        .line_vec  (line_vec)
    );

`ifdef MEDIAN_LB_REPLICATE_EN
    // Top border copies line 0 as it completes; bottom border copies the last
    // line, which sits in line_mid during FLUSH.
    assign border_top = line_vec;
    assign border_bot = line_mid_q;
`else
    assign border_top = '0;
    assign border_bot = '0;
`endif

    always_comb begin
        state_d      = state_q;
        line_top_d   = line_top_q;
        line_mid_d   = line_mid_q;
        line_cnt_d   = line_cnt_q;
        win_out_d    = win_out_q;
        line_idx_d   = line_idx_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        if (state_q == FLUSH) begin
            win_out_d    = {line_top_q, line_mid_q, border_bot};
            line_idx_d   = LAST_LINE;
            win_valid_d  = 1'b1;
            frame_done_d = 1'b1;
            state_d      = IDLE;
        end else if (push && (restart || state_q == FIRST)) begin
            // Line 0 of a (possibly restarted) frame: an sof mid-frame drops
            // the old frame silently; stale line registers are overwritten.
            state_d    = FIRST;
            line_cnt_d = '0;
            if (line_done) begin
                line_top_d = border_top;
                line_mid_d = line_vec;
                line_cnt_d = IDX_W'(1);
                state_d    = STREAM;
            end
        end else if (push && line_done) begin
            win_out_d   = {line_top_q, line_mid_q, line_vec};
            line_idx_d  = line_cnt_q - IDX_W'(1);
            win_valid_d = 1'b1;
            line_top_d  = line_mid_q;
            line_mid_d  = line_vec;
            line_cnt_d  = line_cnt_q + IDX_W'(1);
            if (line_cnt_q == LAST_LINE) begin
                state_d = FLUSH;
            end
        end

        // Registered ready: low only for the single FLUSH cycle.
        pix_ready_d = (state_d != FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            line_top_q   <= '0;
            line_mid_q   <= '0;
            line_cnt_q   <= '0;
            win_out_q    <= '0;
            win_valid_q  <= 1'b0;
            line_idx_q   <= '0;
            frame_done_q <= 1'b0;
            pix_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_top_q   <= line_top_d;
            line_mid_q   <= line_mid_d;
            line_cnt_q   <= line_cnt_d;
            win_out_q    <= win_out_d;
            win_valid_q  <= win_valid_d;
            line_idx_q   <= line_idx_d;
            frame_done_q <= frame_done_d;
            pix_ready_q  <= pix_ready_d;
        end
    end

    assign bus.pix_ready  = pix_ready_q;
    assign bus.win_out    = win_out_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.line_idx   = line_idx_q;
    assign bus.frame_done = frame_done_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_median_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_median_line_buffer
// Directed bench for median_line_buffer with LINE_LEN=4, NUM_LINES=3, WIDTH=8.
// Expected windows are built from the pixels driven and queued with the cycle
// they must appear in; a negedge monitor pops and compares them.
// Honours MEDIAN_LB_REPLICATE_EN for the border line model.
// -----------------------------------------------------------------------------
module tb_median_line_buffer;
    localparam int L  = 4;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int IW = 9;
    localparam int LB = L * W;
    localparam int EW = 3 * LB + IW + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    median_line_buffer_if #(.LINE_LEN(L), .WIDTH(W), .IDX_W(IW)) bus ();

    median_line_buffer #(
        .LINE_LEN  (L),
        .NUM_LINES (N),
        .WIDTH     (W),
        .IDX_W     (IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard entry: {win_out, line_idx, frame_done, pix_ready}
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            n_vec      = 0;
    int            n_err      = 0;
    int            win_seen   = 0;
    int            win_pushed = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [LB-1:0] border_top(input logic [LB-1:0] line0);
`ifdef MEDIAN_LB_REPLICATE_EN
        return line0;
`else
        return (line0 & '0);
`endif
    endfunction

    function automatic logic [LB-1:0] border_bot(input logic [LB-1:0] last_line);
`ifdef MEDIAN_LB_REPLICATE_EN
        return last_line;
`else
        return (last_line & '0);
`endif
    endfunction

    task automatic expect_win(input logic [LB-1:0] t, input logic [LB-1:0] m,
                              input logic [LB-1:0] b, input int idx,
                              input logic fd, input logic rdy, input int c);
        exp_q.push_back({t, m, b, IW'(idx), fd, rdy});
        exp_cyc_q.push_back(c);
        win_pushed++;
    endtask

    // Monitor: every window must match the head of the queue, in its cycle.
    always @(negedge clk) begin
        if (!rst && bus.win_valid) begin
            logic [EW-1:0] e;
            int            c;
            win_seen++;
            if (exp_q.size() == 0) begin
                check("win_unexpected", 128'(exp_q.size()), 128'(1));
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("window", 128'({bus.win_out, bus.line_idx, bus.frame_done, bus.pix_ready}),
                      128'(e));
                check("win_cycle", 128'(cyc), 128'(c));
            end
        end
    end

    // Drives one pixel at the next negedge and returns once it is certain to be
    // accepted on the following posedge; acc is that posedge's cycle number.
    task automatic push_pixel(input logic [W-1:0] d, input logic sof, output int acc);
        int w;
        @(negedge clk);
        bus.pix_data  = d;
        bus.pix_sof   = sof;
        bus.pix_valid = 1'b1;
        w = 0;
        while (!bus.pix_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", 128'(w < 20), 128'(1));
        acc = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.pix_valid = 1'b0;
            bus.pix_sof   = 1'b0;
        end
    endtask

    // Sends the first npix pixels of a frame (value base + position), sof on
    // the first, and queues the windows those pixels must produce.
    task automatic send_frame(input int base, input bit gap, input int npix);
        logic [LB-1:0] lines[N];
        logic [LB-1:0] t;
        logic [W-1:0]  d;
        int            acc;
        int            l;
        int            c;
        for (int p = 0; p < npix; p++) begin
            l = p / L;
            c = p % L;
            d = W'(base + p);
            push_pixel(d, (p == 0), acc);
            lines[l][c*W +: W] = d;
            if (c == L - 1 && l >= 1) begin
                t = (l >= 2) ? lines[l-2] : border_top(lines[0]);
                expect_win(t, lines[l-1], lines[l], l - 1, 1'b0, (l == N - 1) ? 1'b0 : 1'b1, acc);
                if (l == N - 1) begin
                    expect_win(lines[l-1], lines[l], border_bot(lines[l]), N - 1, 1'b1, 1'b1, acc + 1);
                end
            end
            if (gap) idle(1);
        end
        idle(1);
    endtask

    initial begin
        int dummy;
        int seen_before;
        bus.pix_data  = '0;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", 128'({bus.win_out, bus.win_valid, bus.line_idx,
                                     bus.frame_done, bus.pix_ready}), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 128'(bus.pix_ready), 128'(1));
        check("win_valid_after_rst", 128'(bus.win_valid), 128'(0));

        // Back-to-back frame, pixels 0x01..0x0C
        send_frame(32'h01, 1'b0, L * N);
        idle(2);

        // Same frame with valid toggling
        send_frame(32'h01, 1'b1, L * N);
        idle(2);

        // Non-sof pixels in IDLE are dropped
        seen_before = win_seen;
        for (int i = 0; i < 2 * L; i++) begin
            push_pixel(W'(8'h80 + i), 1'b0, dummy);
        end
        idle(3);
        check("idle_drop", 128'(win_seen), 128'(seen_before));
        send_frame(32'h21, 1'b0, L * N);
        idle(2);

        // sof again on the 6th pixel aborts the first frame
        send_frame(32'h41, 1'b0, 5);
        send_frame(32'h51, 1'b0, L * N);
        idle(2);

        // Reset in the middle of line 2
        send_frame(32'h61, 1'b0, 2 * L + 2);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", 128'({bus.win_out, bus.win_valid, bus.line_idx,
                                           bus.frame_done, bus.pix_ready}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst2", 128'(bus.pix_ready), 128'(1));
        send_frame(32'h91, 1'b0, L * N);
        idle(4);

        check("queue_empty", 128'(exp_q.size()), 128'(0));
        check("win_count", 128'(win_seen), 128'(win_pushed));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/median_line_buffer.md
Name: median_line_buffer

Overview:
- Upstream stage of the median filter core. Accepts a raster pixel stream (one WIDTH-bit pixel per handshake) and assembles full image lines.
- Presents 3-line windows (above / centre / below) on a wide bus with a one-cycle enable pulse and a line index. Output format is exactly the core's row_in / en_in / buffer_counter inputs.
- Handles top and bottom image borders and frame restart.

Parameters:
- LINE_LEN, 256, pixels per line (matches the core's row length)
- NUM_LINES, 256, lines per frame; must be >= 2
- WIDTH, 8, bits per pixel
- IDX_W, 9, width of line index / counters

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- pix_data  in  WIDTH  input pixel
- pix_valid  in  1  pixel present
- pix_sof  in  1  qualifies pix_data as column 0 of line 0 of a new frame
- pix_ready  out  1  block can accept a pixel this cycle
- win_out  out  3*LINE_LEN*WIDTH  window to core row_in
- win_valid  out  1  one-cycle pulse, window valid (core en_in)
- line_idx  out  IDX_W  centre-line number of the window (core buffer_counter)
- frame_done  out  1  one-cycle pulse with the last window of a frame

Behaviour:
- Reset (async, rst=1): all outputs 0 except pix_ready=0; all line registers, counters and state cleared. pix_ready rises the first cycle after rst deasserts.
- Window layout:
  - Top line in slice [3*L*W-1 : 2*L*W], centre in the middle slice, bottom in [L*W-1 : 0] (L=LINE_LEN, W=WIDTH).
  - Within each slice, column 0 occupies the least-significant WIDTH bits.
- Storage:
  - line_top and line_mid registers hold completed lines.
  - line_asm is a shift register; each accepted pixel enters at the MS end and the contents shift down by WIDTH. After L pixels, column 0 sits at the LSB.
- Counters:
  - col_cnt runs 0..L-1 and wraps to 0 on the last pixel.
  - line_cnt counts completed lines in the frame.
- Accept: a pixel is transferred when pix_valid && pix_ready.
- States:
  - IDLE: pix_ready=1. Waits for an accepted pixel with pix_sof=1; that pixel becomes column 0, and the state moves to FIRST. Accepted pixels without sof are dropped.
  - FIRST: assembling line 0. On its last pixel: line_mid <= completed line, line_top <= border line, line_cnt=1, go to STREAM. No window is emitted.
  - STREAM: on completion of line n (n>=1), registered output in the next cycle:
    - win_out = {line_top, line_mid, completed line}, line_idx = n-1, win_valid=1.
    - Then line_top <= line_mid, line_mid <= completed line.
    - If n == NUM_LINES-1, go to FLUSH.
  - FLUSH (exactly 1 cycle, pix_ready=0):
    - Next cycle: win_out = {line_top, line_mid, border line}, line_idx = NUM_LINES-1, win_valid=1, frame_done=1.
    - Then go to IDLE.
- Latency: win_valid is asserted 1 cycle after the handshake of the last pixel of a line. The final window follows 1 cycle after the previous window.
- Throughput: one pixel per cycle, except during the single FLUSH cycle.
- Border line: all-zero pixels.
- pix_sof mid-frame (FIRST or STREAM, accepted pixel):
  - Aborts the current frame with no flush window and no frame_done.
  - Restarts in FIRST with this pixel as column 0; line registers are not cleared (they are overwritten).
- pix_sof in IDLE on a non-first pixel cannot occur; sof is always honoured.
- pix_valid low mid-line: the block holds state indefinitely, with no timeout.
- win_valid never asserts on two consecutive cycles except the STREAM-last-line to FLUSH pair.
- win_out holds its last value between pulses.

Optional Feature:
- Macro MEDIAN_LB_REPLICATE_EN.
- Defined: the border line is a replica of the nearest edge line.
  - Top border = line 0 (line_top <= completed line 0 in FIRST).
  - Bottom border = last line (the flush window is {line_top, line_mid, line_mid}).
- Undefined: the border is all zeros, as above.
- No port or latency change either way.

Decomposition:
- Shared package median_pkg holds:
  - default constants LINE_LEN=256, NUM_LINES=256, WIDTH=8, IDX_W=9, shared with the core and CSR;
  - the state enum (IDLE, FIRST, STREAM, FLUSH);
  - localparam LINE_BITS = LINE_LEN*WIDTH.
- One natural sub-module, median_line_asm: the shift-register assembler plus col_cnt, producing line_done and the line vector. The FSM and window register stay in median_line_buffer.

Test Plan (bench uses LINE_LEN=4, NUM_LINES=3, WIDTH=8):
- Reset, then a frame of pixels 0x01..0x0C with sof on the first and valid every cycle -> 3 windows:
  - idx0 = {00000000, 04030201, 08070605}
  - idx1 = {04030201, 08070605, 0C0B0A09}
  - idx2 = {08070605, 0C0B0A09, 00000000} with frame_done
  - Each window is 1 cycle after its line's last pixel. Windows are written as each slice's 32-bit hex value (column 0 = LSB).
- Same frame with pix_valid toggling 1/0 -> identical windows; pix_ready=0 only in the FLUSH cycle.
- Pixels sent without sof from IDLE -> dropped; no win_valid until a sof pixel arrives.
- sof asserted again at the 6th pixel -> no window for the aborted frame; the new frame's windows are correct with idx starting at 0.
- rst asserted mid-line 2 -> all outputs 0 immediately; the next full frame produces correct windows.
- With MEDIAN_LB_REPLICATE_EN, the first frame -> idx0 top slice = 04030201 and idx2 bottom slice = 0C0B0A09.
